// File: rtl/sensor_conditioner_if.sv
// Signal bundle between the sensor conditioner and its environment.
// master drives the session/sample inputs; slave is the conditioner itself.
interface sensor_conditioner_if #(
  parameter int EW = 8
);
  logic          start;
  logic          sensor_raw;
  logic          actuator;
  logic          sensor;
  logic          settled;
  logic [EW-1:0] edge_count;
  logic          fault;

  modport master (
    output start, sensor_raw, actuator,
    input  sensor, settled, edge_count, fault
  );

  modport slave (
    input  start, sensor_raw, actuator,
    output sensor, settled, edge_count, fault
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Debounces a raw sensor sample with a saturating hysteresis integrator and dwell lockout.
// Optional actuator-follow fault monitor: define SENSOR_FOLLOW_FAULT_EN.
module sensor_conditioner #(
  parameter int INT_MAX       = 15,
  parameter int HI_TH         = 12,
  parameter int LO_TH         = 3,
  parameter int MIN_HOLD      = 8,
  parameter int EW            = 8,
  parameter int FAULT_TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  sensor_conditioner_if.slave bus
);
  localparam int CW = $clog2(INT_MAX + 1);
  localparam int DW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam logic [CW-1:0] TOP = CW'(INT_MAX);
  localparam logic [CW-1:0] HI  = CW'(HI_TH);
  localparam logic [CW-1:0] LO  = CW'(LO_TH);
  localparam logic [DW-1:0] MH  = DW'(MIN_HOLD);

  if (!(LO_TH < HI_TH && HI_TH <= INT_MAX)) begin : g_bad_th
    $error("sensor_conditioner: thresholds must satisfy LO_TH < HI_TH <= INT_MAX");
  end
  if (FAULT_TIMEOUT < 1) begin : g_bad_to
    $error("sensor_conditioner: FAULT_TIMEOUT must be at least 1");
  end

  typedef enum logic {S_LOW = 1'b0, S_HIGH = 1'b1} state_t;

  state_t        state, state_d;
  logic          raw_m, raw_s;
  logic          start_q;
  logic [CW-1:0] integ, integ_d;
  logic [DW-1:0] dwell, dwell_dec, dwell_d;
  logic [EW-1:0] edge_cnt, edge_cnt_d;
  logic          change;
  logic          sensor_w, settled_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_m    <= 1'b0;
      raw_s    <= 1'b0;
      start_q  <= 1'b0;
      integ    <= '0;
      dwell    <= '0;
      edge_cnt <= '0;
    end else begin
      raw_m    <= bus.sensor_raw;
      raw_s    <= raw_m;
      start_q  <= bus.start;
      integ    <= integ_d;
      dwell    <= dwell_d;
      edge_cnt <= edge_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOW;
    else     state <= state_d;
  end

  // Thresholds and lockout are judged on the values the integrator and dwell
  // counter take at this edge, so sensor moves on the edge the crossing lands.
  always_comb begin
    integ_d = integ;
    if (raw_s) begin
      if (integ != TOP) integ_d = integ + 1'b1;
    end else if (integ != '0) begin
      integ_d = integ - 1'b1;
    end

    dwell_dec = (dwell == '0) ? '0 : dwell - 1'b1;

    state_d = state;
    case (state)
      S_LOW:   if (integ_d >= HI && dwell_dec == '0) state_d = S_HIGH;
      S_HIGH:  if (integ_d <= LO && dwell_dec == '0) state_d = S_LOW;
      default: state_d = S_LOW;
    endcase

    change  = (state_d != state);
    dwell_d = change ? MH : dwell_dec;

    // A session restart clears the count before this edge's transition is added.
    edge_cnt_d = edge_cnt;
    if (bus.start && !start_q) edge_cnt_d = change ? EW'(1) : '0;
    else if (bus.start && change) edge_cnt_d = edge_cnt + 1'b1;
  end

  assign sensor_w       = (state == S_HIGH);
  assign settled_w      = (dwell == '0);
  assign bus.sensor     = sensor_w;
  assign bus.settled    = settled_w;
  assign bus.edge_count = edge_cnt;

`ifdef SENSOR_FOLLOW_FAULT_EN
  localparam int FW = $clog2(FAULT_TIMEOUT + 1);
  localparam logic [FW-1:0] FT = FW'(FAULT_TIMEOUT);

  logic          act_m, act_s;
  logic [FW-1:0] mcnt, mcnt_d;
  logic          fault_q, fault_d;

  always_comb begin
    mcnt_d = '0;
    if (bus.start && settled_w && (act_s != sensor_w))
      mcnt_d = (mcnt == FT) ? FT : mcnt + 1'b1;
    fault_d = fault_q;
    if (start_q && !bus.start) fault_d = 1'b0;
    else if (mcnt_d == FT)     fault_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_m   <= 1'b0;
      act_s   <= 1'b0;
      mcnt    <= '0;
      fault_q <= 1'b0;
    end else begin
      act_m   <= bus.actuator;
      act_s   <= act_m;
      mcnt    <= mcnt_d;
      fault_q <= fault_d;
    end
  end

  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif
endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: stimulus queues cycle-stamped expectations,
// a negedge monitor compares them when their cycle arrives.
module tb_sensor_conditioner;
  localparam int MH = 20;
  localparam int EW = 8;
`ifdef SENSOR_FOLLOW_FAULT_EN
  localparam logic FEN = 1'b1;
`else
  localparam logic FEN = 1'b0;
`endif
  localparam logic [3:0] MS = 4'b1000;
  localparam logic [3:0] MT = 4'b0100;
  localparam logic [3:0] ME = 4'b0010;
  localparam logic [3:0] MF = 4'b0001;

  typedef struct {
    int            cyc;
    string         name;
    logic [3:0]    mask;
    logic          s;
    logic          st;
    logic [EW-1:0] ec;
    logic          f;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  sensor_conditioner_if #(.EW(EW)) bus ();

  sensor_conditioner #(
    .INT_MAX(15), .HI_TH(12), .LO_TH(3), .MIN_HOLD(MH), .EW(EW), .FAULT_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input string n, input logic [3:0] m, input logic s, input logic st,
                         input logic [EW-1:0] ec, input logic f);
    logic ok;
    ok = 1'b1;
    total++;
    if (m[3] && bus.sensor !== s)      ok = 1'b0;
    if (m[2] && bus.settled !== st)    ok = 1'b0;
    if (m[1] && bus.edge_count !== ec) ok = 1'b0;
    if (m[0] && bus.fault !== f)       ok = 1'b0;
    if (!ok) begin
      bad++;
      $display("FAIL %s cyc=%0d mask=%b: got sensor=%b settled=%b edge_count=%0d fault=%b, want sensor=%b settled=%b edge_count=%0d fault=%b",
               n, cyc, m, bus.sensor, bus.settled, bus.edge_count, bus.fault, s, st, ec, f);
    end
  endtask

  task automatic push(input int c, input string n, input logic [3:0] m, input logic s,
                      input logic st, input logic [EW-1:0] ec, input logic f);
    exp_t e;
    e.cyc = c; e.name = n; e.mask = m; e.s = s; e.st = st; e.ec = ec; e.f = f;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic step(input logic lvl, output int c);
    @(negedge clk);
    bus.sensor_raw = lvl;
    c = cyc;
  endtask

  // Monitor: outputs are stable at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          compare(sb[i].name, sb[i].mask, sb[i].s, sb[i].st, sb[i].ec, sb[i].f);
          sb.delete(i);
        end else if (sb[i].cyc < cyc) begin
          total++;
          bad++;
          $display("FAIL %s: expectation for cycle %0d never evaluated (now %0d)", sb[i].name, sb[i].cyc, cyc);
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    int c0, g0, f0, r0, x0, z0, s, e0;
    bus.start = 1'b0;
    bus.sensor_raw = 1'b0;
    bus.actuator = 1'b0;
    #1 rst = 1'b1;
    #1 compare("reset", MS | MT | ME | MF, 1'b0, 1'b1, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Debounce latency and dwell length
    wait_until(cyc + 20);
    step(1'b1, c0);
    push(c0 + 13, "rise_pre", MS | ME | MF, 1'b0, 1'b0, '0, 1'b0);
    push(c0 + 14, "rise", MS | MT | ME | MF, 1'b1, 1'b0, '0, 1'b0);
    push(c0 + 33, "dwell_last", MS | MT, 1'b1, 1'b0, '0, 1'b0);
    push(c0 + 34, "dwell_done", MS | MT, 1'b1, 1'b1, '0, 1'b0);
    wait_until(c0 + 40);

    // Five-cycle glitch from the saturated high rail
    step(1'b0, g0);
    for (int k = 4; k <= 20; k += 4)
      push(g0 + k, "glitch_hold", MS | MT | ME, 1'b1, 1'b1, '0, 1'b0);
    wait_until(g0 + 5);
    bus.sensor_raw = 1'b1;
    wait_until(g0 + 30);

    // Fall latency, then lockout deferring an immediate fall
    step(1'b0, f0);
    push(f0 + 13, "fall_pre", MS, 1'b1, 1'b0, '0, 1'b0);
    push(f0 + 14, "fall", MS | MT | ME, 1'b0, 1'b0, '0, 1'b0);
    wait_until(f0 + 40);
    step(1'b1, r0);
    push(r0 + 14, "lock_rise", MS | MT | ME, 1'b1, 1'b0, '0, 1'b0);
    push(r0 + 27, "lock_defer", MS | MT, 1'b1, 1'b0, '0, 1'b0);
    push(r0 + 33, "lock_defer_last", MS | MT, 1'b1, 1'b0, '0, 1'b0);
    push(r0 + 34, "lock_fall", MS | MT | ME, 1'b0, 1'b0, '0, 1'b0);
    wait_until(r0 + 14);
    bus.sensor_raw = 1'b0;
    wait_until(r0 + 60);

    // Async reset with the integrator part way up
    step(1'b1, x0);
    wait_until(x0 + 11);
    #2 rst = 1'b1;
    #1 compare("async_rst", MS | MT | ME | MF, 1'b0, 1'b1, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    z0 = cyc;
    push(z0 + 13, "rst_rise_pre", MS, 1'b0, 1'b0, '0, 1'b0);
    push(z0 + 14, "rst_rise", MS | MT, 1'b1, 1'b0, '0, 1'b0);
    wait_until(z0 + 40);

    // Session counting
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step((i % 2) == 1, s);
      push(s + 13, "sess_pre", ME, 1'b0, 1'b0, EW'(i), 1'b0);
      push(s + 14, "sess_edge", MS | ME | MF, (i % 2) == 1, 1'b0, EW'(i + 1), 1'b0);
      wait_until(s + 36);
    end
    bus.start = 1'b0;
    step(1'b0, s);
    push(s + 14, "hold_no_start", MS | ME, 1'b0, 1'b0, EW'(4), 1'b0);
    wait_until(s + 36);
    step(1'b1, s);
    push(s + 13, "coinc_pre", ME, 1'b0, 1'b0, EW'(4), 1'b0);
    push(s + 14, "coinc_clear", MS | ME | MF, 1'b1, 1'b0, EW'(1), 1'b0);
    wait_until(s + 13);
    bus.start = 1'b1;

    // Actuator-follow fault (stays 0 when the monitor is not built)
    e0 = s;
    push(e0 + 97, "fault_pre", MF, 1'b0, 1'b0, '0, 1'b0);
    push(e0 + 98, "fault_set", MS | MF, 1'b1, 1'b0, '0, FEN);
    push(e0 + 110, "fault_sticky", MF, 1'b0, 1'b0, '0, FEN);
    push(e0 + 112, "fault_pre_stop", MF, 1'b0, 1'b0, '0, FEN);
    push(e0 + 113, "fault_clr", ME | MF, 1'b0, 1'b0, EW'(1), 1'b0);
    wait_until(e0 + 100);
    bus.actuator = 1'b1;
    wait_until(e0 + 112);
    bus.start = 1'b0;
    wait_until(e0 + 120);

    // Reset while high with a non-zero count
    #2 rst = 1'b1;
    #1 compare("final_rst", MS | MT | ME | MF, 1'b0, 1'b1, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);

    foreach (sb[i]) begin
      total++;
      bad++;
      $display("FAIL %s: expectation for cycle %0d left pending", sb[i].name, sb[i].cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
